// File: rtl/r_rom_ft245_bridge.sv
`default_nettype none
// ============================================================================
// Module   : r_rom_ft245_bridge
// Purpose  : Byte-level back end of the remote-ROM path. Drains the command
//            FIFO (address bytes) into an FT245-style synchronous USB FIFO
//            chip, and moves bytes returned by the host from the chip into
//            the response FIFO. The chip data bus is shared by both directions
//            and is time-multiplexed by a round-robin arbiter. Each grant is
//            limited to BURST bytes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n            system clock / asynchronous active-low reset
//   cmd_empty, cmd_rd_en  command FIFO status / pop (data valid next cycle)
//   cmd_dout              command FIFO read data
//   resp_full, resp_wr_en response FIFO status / push
//   resp_din              response FIFO write data
//   ft_rxf_n, ft_txe_n    chip RX-data-available / TX-space-available (low)
//   ft_data_i/_o/_oe      chip data bus in / out / bridge drive enable
//   ft_rd_n, ft_wr_n      chip read / write strobes (active low)
//   ft_oe_n               chip output enable (active low)
//   ft_siwu_n             send-immediate strobe, held inactive
// ============================================================================
module r_rom_ft245_bridge #(
  parameter int BURST = 64,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_empty,
  output logic       cmd_rd_en,
  input  logic [7:0] cmd_dout,
  input  logic       resp_full,
  output logic       resp_wr_en,
  output logic [7:0] resp_din,
  input  logic       ft_rxf_n,
  input  logic       ft_txe_n,
  input  logic [7:0] ft_data_i,
  output logic [7:0] ft_data_o,
  output logic       ft_data_oe,
  output logic       ft_rd_n,
  output logic       ft_wr_n,
  output logic       ft_oe_n,
  output logic       ft_siwu_n
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_FETCH = 3'd1,
    S_TX_WRITE = 3'd2,
    S_RX_TURN  = 3'd3,
    S_RX       = 3'd4
  } state_t;

  // One extra bit so the counter can be compared against BURST after the
  // increment without wrapping.
  typedef logic [CNT_W:0] cnt_ext_t;
  localparam cnt_ext_t C_BURST = cnt_ext_t'(BURST);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_rx_q, last_rx_d;   // 1 = last grant went to RX

  logic             w_rx_req;
  logic             w_tx_req;
  logic             w_rx_go;
  cnt_ext_t         w_cnt_inc;

  assign w_rx_req  = ~ft_rxf_n & ~resp_full;
  assign w_tx_req  = ~ft_txe_n & ~cmd_empty;
  assign w_cnt_inc = cnt_ext_t'(cnt_q) + cnt_ext_t'(1);
  assign w_rx_go   = ~ft_rxf_n & ~resp_full & (cnt_ext_t'(cnt_q) < C_BURST);

  // Output decode. The strobes that must react to chip/FIFO status in the
  // same cycle (wr_n, rd_n, resp_wr_en) are gated combinationally; all other
  // outputs are pure decodes of the state register.
  assign cmd_rd_en  = (state_q == S_TX_FETCH);
  assign ft_data_oe = (state_q == S_TX_WRITE);
  // While stalled in S_TX_WRITE the command FIFO is not popped, so its output
  // register keeps presenting the same byte.
  assign ft_data_o  = (state_q == S_TX_WRITE) ? cmd_dout : 8'h00;
  assign ft_wr_n    = ~((state_q == S_TX_WRITE) & ~ft_txe_n);
  // The chip only drives the bus while the bridge has released it, so oe_n
  // and data_oe are decoded from disjoint states.
  assign ft_oe_n    = ~((state_q == S_RX_TURN) | (state_q == S_RX));
  assign ft_rd_n    = ~((state_q == S_RX) & w_rx_go);
  assign resp_wr_en = (state_q == S_RX) & w_rx_go;
  assign resp_din   = (state_q == S_RX) ? ft_data_i : 8'h00;
  assign ft_siwu_n  = 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rx_d = last_rx_q;
    case (state_q)
      S_IDLE: begin
        // Round robin: RX wins when TX had the previous grant or TX is idle.
        if (w_rx_req && (!last_rx_q || !w_tx_req)) begin
          state_d   = S_RX_TURN;
          last_rx_d = 1'b1;
          cnt_d     = '0;
        end else if (w_tx_req) begin
          state_d   = S_TX_FETCH;
          last_rx_d = 1'b0;
          cnt_d     = '0;
        end
      end
      S_TX_FETCH: begin
        state_d = S_TX_WRITE;
      end
      S_TX_WRITE: begin
        if (!ft_txe_n) begin
          cnt_d = w_cnt_inc[CNT_W-1:0];
          if ((w_cnt_inc < C_BURST) && !cmd_empty) begin
            state_d = S_TX_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RX_TURN: begin
        state_d = S_RX;
      end
      S_RX: begin
        if (w_rx_go) begin
          cnt_d = w_cnt_inc[CNT_W-1:0];
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_rx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rx_q <= last_rx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_r_rom_ft245_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_r_rom_ft245_bridge
// Purpose  : Self-checking bench for r_rom_ft245_bridge. Models the command
//            FIFO, response FIFO and FT245 chip with queues; expected byte
//            streams are queued by the stimulus and consumed by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_r_rom_ft245_bridge;

  localparam int BURST = 4;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_empty, cmd_rd_en, resp_full, resp_wr_en;
  logic [7:0] cmd_dout, resp_din, ft_data_i, ft_data_o;
  logic       ft_rxf_n, ft_txe_n, ft_data_oe, ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n;

  always #5 clk = ~clk;

  r_rom_ft245_bridge #(.BURST(BURST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_empty(cmd_empty), .cmd_rd_en(cmd_rd_en), .cmd_dout(cmd_dout),
    .resp_full(resp_full), .resp_wr_en(resp_wr_en), .resp_din(resp_din),
    .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n), .ft_data_i(ft_data_i),
    .ft_data_o(ft_data_o), .ft_data_oe(ft_data_oe), .ft_rd_n(ft_rd_n),
    .ft_wr_n(ft_wr_n), .ft_oe_n(ft_oe_n), .ft_siwu_n(ft_siwu_n)
  );

  // Environment model state
  logic [7:0] cmd_q[$];     // command FIFO contents
  logic [7:0] host_q[$];    // bytes the host will return through the chip
  logic [7:0] exp_tx[$];    // scoreboard: bytes the chip must receive, in order
  logic [7:0] exp_rx[$];    // scoreboard: bytes the response FIFO must receive
  bit         tx_block = 1'b1;
  bit         rx_block = 1'b1;
  int         resp_lvl = 0;
  int         resp_cap = 1000;
  bit         strict_tx = 1'b1;

  // Monitor results
  int  checks = 0, errors = 0;
  bit  s_wr, s_rd, s_crd, s_rwe;
  int  tx_sent = 0, rx_got = 0, crd_cnt = 0, tx_cycles = 0;
  int  g_cyc = 0, g_bytes = 0;
  bit  g_rx = 1'b0;
  bit  glog_rx[$];
  int  glog_n[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void refresh();
    cmd_empty = (cmd_q.size() == 0);
    ft_txe_n  = tx_block;
    ft_rxf_n  = rx_block | (host_q.size() == 0);
    ft_data_i = (host_q.size() != 0) ? host_q[0] : 8'h00;
    resp_full = (resp_lvl >= resp_cap);
  endfunction

  // Advance one clock and apply the consequences of the strobes the monitor
  // saw before that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (s_crd && cmd_q.size() != 0) cmd_dout = cmd_q.pop_front();
    if (s_rd && host_q.size() != 0) void'(host_q.pop_front());
    if (s_rwe) resp_lvl++;
    refresh();
  endtask

  task automatic push_cmd(input logic [7:0] b);
    cmd_q.push_back(b);
    exp_tx.push_back(b);
  endtask

  task automatic push_host(input logic [7:0] b);
    host_q.push_back(b);
    exp_rx.push_back(b);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(exp_tx.size() == 0 && exp_rx.size() == 0 && g_cyc == 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("drain_timeout", n, 0);
  endtask

  // Monitor: samples mid-cycle, checks invariants and the byte scoreboards,
  // and segments activity into grants separated by idle cycles.
  always @(negedge clk) begin
    logic [7:0] e;
    bit idle;
    s_wr  = rst_n && !ft_wr_n;
    s_rd  = rst_n && !ft_rd_n;
    s_crd = rst_n && cmd_rd_en;
    s_rwe = rst_n && resp_wr_en;
    chk("bus_contention", int'(ft_data_oe && !ft_oe_n), 0);
    chk("flow_guard", int'((resp_wr_en && resp_full) || (cmd_rd_en && cmd_empty) ||
                           (!ft_wr_n && ft_txe_n) || (!ft_rd_n && (ft_rxf_n || resp_full))), 0);
    if (s_crd) crd_cnt++;
    if (ft_data_oe) begin
      if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
      else if (s_wr) begin
        e = exp_tx.pop_front();
        chk("tx_byte", ft_data_o, e);
      end else chk("tx_hold", ft_data_o, exp_tx[0]);
    end else if (s_wr) chk("tx_wr_without_oe", 1, 0);
    if (s_wr) tx_sent++;
    if (s_rwe) begin
      if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
      else begin
        e = exp_rx.pop_front();
        chk("rx_byte", resp_din, e);
      end
      rx_got++;
    end
    chk("rd_vs_push", int'(s_rd), int'(s_rwe));
    idle = !cmd_rd_en && !ft_data_oe && ft_oe_n;
    if (!idle) begin
      if (g_cyc == 0) begin
        g_rx = !ft_oe_n;
        if (g_rx) chk("rx_turnaround", int'(ft_rd_n), 1);
      end
      g_cyc++;
      if (s_wr || s_rd) g_bytes++;
    end else if (g_cyc > 0) begin
      chk("burst_limit", int'(g_bytes > BURST), 0);
      if (g_rx) chk("rx_grant_len", g_cyc, g_bytes + 2);
      else if (strict_tx) chk("tx_grant_len", g_cyc, 2 * g_bytes);
      if (!g_rx) tx_cycles += g_cyc;
      glog_rx.push_back(g_rx);
      glog_n.push_back(g_bytes);
      g_cyc = 0;
      g_bytes = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, b2, gb, n;
    cmd_dout = 8'h00;
    refresh();
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_wr_n", ft_wr_n, 1);
    chk("rst_rd_n", ft_rd_n, 1);
    chk("rst_oe_n", ft_oe_n, 1);
    chk("rst_data_oe", ft_data_oe, 0);
    chk("rst_cmd_rd_en", cmd_rd_en, 0);
    chk("rst_resp_wr_en", resp_wr_en, 0);
    chk("rst_data_o", ft_data_o, 0);
    chk("rst_resp_din", resp_din, 0);
    chk("siwu_n", ft_siwu_n, 1);
    rst_n = 1'b1;
    tick();

    // TX only: 8 bytes, two grants of 4, 2 cycles per byte
    for (int i = 0; i < 8; i++) push_cmd(8'(i));
    b0 = tx_sent; b1 = crd_cnt; b2 = tx_cycles;
    tx_block = 1'b0;
    refresh();
    wait_done(200);
    chk("tx8_wr_pulses", tx_sent - b0, 8);
    chk("tx8_pops", crd_cnt - b1, 8);
    chk("tx8_cycles", tx_cycles - b2, 16);

    // RX only: host returns 0x11..0x18
    for (int i = 0; i < 8; i++) push_host(8'(8'h11 + i));
    b0 = rx_got;
    rx_block = 1'b0;
    refresh();
    wait_done(200);
    chk("rx8_pushes", rx_got - b0, 8);

    // Response FIFO fills after 2 bytes mid-burst, then drains
    resp_lvl = 0;
    resp_cap = 2;
    for (int i = 0; i < 8; i++) push_host(8'($urandom));
    b0 = rx_got;
    refresh();
    repeat (20) tick();
    chk("rx_full_stop", rx_got - b0, 2);
    chk("rx_full_host_left", host_q.size(), 6);
    resp_lvl = 0;
    resp_cap = 1000;
    refresh();
    wait_done(200);
    chk("rx_full_resume", rx_got - b0, 8);

    // TX stall: txe_n high for 5 cycles after the 3rd byte
    for (int i = 0; i < 8; i++) push_cmd(8'(i));
    b0 = tx_sent;
    strict_tx = 1'b0;
    n = 0;
    while (tx_sent - b0 < 3 && n < 100) begin tick(); n++; end
    chk("stall_reach3", tx_sent - b0, 3);
    tx_block = 1'b1;
    refresh();
    repeat (5) tick();
    chk("stall_no_send", tx_sent - b0, 3);
    chk("stall_data_o", ft_data_o, 8'h03);
    tx_block = 1'b0;
    refresh();
    wait_done(200);
    chk("stall_total", tx_sent - b0, 8);
    strict_tx = 1'b1;

    // Both directions pending: grants alternate RX,TX,RX,TX with BURST bytes
    tx_block = 1'b1;
    rx_block = 1'b1;
    refresh();
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      push_cmd(8'($urandom));
      push_host(8'($urandom));
    end
    gb = glog_n.size();
    tx_block = 1'b0;
    rx_block = 1'b0;
    refresh();
    wait_done(300);
    chk("alt_grant_count", glog_n.size() - gb, 4);
    for (int k = 0; k < 4; k++) begin
      if (gb + k < glog_n.size()) begin
        chk("alt_grant_bytes", glog_n[gb + k], BURST);
        chk("alt_grant_dir_rx", int'(glog_rx[gb + k]), int'(k % 2 == 0));
      end
    end

    // Reset while stalled in the write state
    strict_tx = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(8'(8'hA0 + i));
    b0 = tx_sent;
    n = 0;
    while (tx_sent - b0 < 1 && n < 100) begin tick(); n++; end
    tx_block = 1'b1;
    refresh();
    repeat (2) tick();
    chk("rstmid_in_write", ft_data_oe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_data_oe", ft_data_oe, 0);
    chk("rstmid_wr_n", ft_wr_n, 1);
    chk("rstmid_cmd_rd_en", cmd_rd_en, 0);
    chk("rstmid_data_o", ft_data_o, 0);
    b1 = crd_cnt;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rstmid_no_pop", crd_cnt - b1, 0);
    chk("rstmid_fifo_left", cmd_q.size(), 2);
    void'(exp_tx.pop_front());   // byte popped before reset is gone
    tx_block = 1'b0;
    refresh();
    wait_done(200);
    chk("rstmid_total", tx_sent - b0, 3);

    // Randomised traffic with chip and FIFO back-pressure
    resp_cap = 6;
    resp_lvl = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && cmd_q.size() < 16) push_cmd(8'($urandom));
      if ($urandom_range(0, 3) == 0 && host_q.size() < 16) push_host(8'($urandom));
      tx_block = ($urandom_range(0, 4) == 0);
      rx_block = ($urandom_range(0, 4) == 0);
      if (resp_lvl > 0 && $urandom_range(0, 2) == 0) resp_lvl--;
      refresh();
      tick();
    end
    tx_block = 1'b0;
    rx_block = 1'b0;
    resp_cap = 1000;
    refresh();
    wait_done(2000);
    chk("final_tx_empty", exp_tx.size(), 0);
    chk("final_rx_empty", exp_rx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
